lif_spike_monitor: RTL and testbench

- Sits downstream of an LIF neuron and watches its Q16.16 membrane-voltage output stream.
- Detects firing events: a sample of exactly zero that follows a positive sample.
- Each event is tagged with a timestamp and an inter-spike interval (ISI), both counted in neuron updates.
- Events are buffered in a small FIFO and delivered to the consumer (spike router / logger) over a valid/ready handshake.

---
 rtl/lif_pkg.sv | 16 +
 rtl/spike_event_fifo.sv | 50 +++++
 rtl/lif_spike_monitor.sv | 90 +++++++++
 tb/tb_lif_spike_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF spike monitor slice.
// Q16.16 membrane format, default event field widths, event record.
package lif_pkg;

  localparam int Q_FRAC = 16;
  localparam logic signed [31:0] Q_ONE = 32'sh0001_0000;

  localparam int TS_W_DEF  = 16;
  localparam int ISI_W_DEF = 16;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [ISI_W_DEF-1:0] isi;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous FIFO for spike events; head is read combinationally from storage.
// Push into a full FIFO succeeds only when a pop happens on the same edge.
module spike_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the consumer only sees it behind a non-empty flag.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Watches a Q16.16 LIF membrane stream, detects zero-after-positive firing
// events and queues {timestamp, ISI} records for a valid/ready consumer.
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int TS_W       = TS_W_DEF,
  parameter int ISI_W      = ISI_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic signed [31:0] vout,
  input  logic               vout_valid,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic [TS_W-1:0]    spike_ts,
  output logic [ISI_W-1:0]   spike_isi,
  output logic [CNT_W-1:0]   spike_count,
  output logic               overflow
);

  function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic signed [31:0]       prev_v_p0;
  logic [TS_W-1:0]          ts_cnt_p0;
  logic [ISI_W-1:0]         isi_cnt_p0;
  logic                     spike_det;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [TS_W+ISI_W-1:0]    fifo_din;
  logic [TS_W+ISI_W-1:0]    fifo_dout;

  assign spike_det = vout_valid && (vout == 32'sd0) && (prev_v_p0 > 32'sd0);
  assign fifo_push = spike_det && !clear;
  assign fifo_pop  = spike_ready && !clear;
  assign fifo_din  = {ts_cnt_p0, isi_sat_inc(isi_cnt_p0)};

  // Sample stage: previous voltage, update timestamp, ISI and spike counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_v_p0   <= '0;
      ts_cnt_p0   <= '0;
      isi_cnt_p0  <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      prev_v_p0   <= '0;
      ts_cnt_p0   <= '0;
      isi_cnt_p0  <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (vout_valid) begin
        prev_v_p0  <= vout;
        ts_cnt_p0  <= ts_cnt_p0 + 1'b1;
        isi_cnt_p0 <= spike_det ? '0 : isi_sat_inc(isi_cnt_p0);
      end
      if (spike_det) begin
        spike_count <= spike_count + 1'b1;
        // A full FIFO frees a slot only if the head is taken on this edge.
        if (fifo_full && !spike_ready) overflow <= 1'b1;
      end
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TS_W + ISI_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign spike_valid           = !fifo_empty;
  assign {spike_ts, spike_isi} = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Bench for lif_spike_monitor: event-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lif_spike_monitor;
  import lif_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] vout = '0;
  logic        vout_valid = 1'b0;
  logic        spike_ready = 1'b0;
  logic        spike_valid;
  logic [15:0] spike_ts;
  logic [15:0] spike_isi;
  logic [15:0] spike_count;
  logic        overflow;

  always #5 clk = ~clk;

  lif_spike_monitor #(
    .TS_W(16), .ISI_W(16), .FIFO_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .vout        (vout),
    .vout_valid  (vout_valid),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_ts    (spike_ts),
    .spike_isi   (spike_isi),
    .spike_count (spike_count),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending events plus plain integer counters.
  spike_event_t mq[$];
  spike_event_t m_ev;
  int m_ts = 0;
  int m_since = 0;
  int m_prev = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_spk;
  bit m_full;

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_since = 0; m_prev = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else if (clear) model_reset();
    else begin
      m_spk  = vout_valid && (vout == 32'd0) && (m_prev > 0);
      m_full = (mq.size() == 4);
      if (spike_ready && mq.size() > 0) void'(mq.pop_front());
      if (vout_valid) m_since++;
      if (m_spk) begin
        m_cnt++;
        if (m_full && !spike_ready) m_ovf = 1'b1;
        else begin
          m_ev.ts  = 16'(m_ts);
          m_ev.isi = (m_since > 65535) ? 16'hFFFF : 16'(m_since);
          mq.push_back(m_ev);
        end
        m_since = 0;
      end
      if (vout_valid) begin
        m_prev = $signed(vout);
        m_ts   = (m_ts + 1) % 65536;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(spike_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("ts", 32'(spike_ts), 32'(mq[0].ts));
        chk("isi", 32'(spike_isi), 32'(mq[0].isi));
      end
      chk("count", 32'(spike_count), 32'(m_cnt[15:0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic cyc(input bit vv, input logic [31:0] v, input bit rdy, input bit clr = 1'b0);
    vout_valid = vv; vout = v; spike_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic spikes(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 32'h8000, rdy);
      cyc(1'b1, 32'h0000, rdy);
    end
  endtask

  logic [31:0] rv;

  initial begin
    // Reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_en = 1'b1;
    end
    chk("rst_valid", 32'(spike_valid), 32'd0);
    chk("rst_count", 32'(spike_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("idle_valid", 32'(spike_valid), 32'd0);

    // Basic spikes
    cyc(1'b1, 32'h2000, 1'b1);
    cyc(1'b1, 32'h4000, 1'b1);
    cyc(1'b1, 32'h0000, 1'b1);
    chk("basic_valid", 32'(spike_valid), 32'd1);
    chk("basic_ts", 32'(spike_ts), 32'd2);
    chk("basic_isi", 32'(spike_isi), 32'd3);
    chk("basic_count", 32'(spike_count), 32'd1);
    cyc(1'b1, 32'h3000, 1'b1);
    chk("basic_popped", 32'(spike_valid), 32'd0);
    cyc(1'b1, 32'h0000, 1'b1);
    chk("basic2_ts", 32'(spike_ts), 32'd4);
    chk("basic2_isi", 32'(spike_isi), 32'd2);
    chk("basic2_count", 32'(spike_count), 32'd2);
    cyc(1'b0, 32'h0, 1'b1);

    // Non-spikes, then a spike revealing the timestamp position
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0000, 1'b1);
    cyc(1'b1, 32'h0000_0000, 1'b1);
    cyc(1'b1, 32'hFFFF_E000, 1'b1);
    cyc(1'b1, 32'h0000_0000, 1'b1);
    chk("nonspk_valid", 32'(spike_valid), 32'd0);
    chk("nonspk_count", 32'(spike_count), 32'd0);
    cyc(1'b1, 32'h8000, 1'b1);
    cyc(1'b1, 32'h0000, 1'b1);
    chk("nonspk_ts", 32'(spike_ts), 32'd5);
    chk("nonspk_isi", 32'(spike_isi), 32'd6);
    cyc(1'b0, 32'h0, 1'b1);

    // Overflow: six spikes with no consumer
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    spikes(6, 1'b0);
    chk("ovf_count", 32'(spike_count), 32'd6);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_isi0", 32'(spike_isi), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_ts", 32'(spike_ts), 32'(1 + 2 * k));
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("ovf_drained", 32'(spike_valid), 32'd0);

    // Full FIFO with pop and push on the same edge
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    spikes(4, 1'b0);
    cyc(1'b1, 32'h8000, 1'b0);
    cyc(1'b1, 32'h0000, 1'b1);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_count", 32'(spike_count), 32'd5);
    for (int k = 0; k < 4; k++) begin
      chk("fpp_drain_ts", 32'(spike_ts), 32'(3 + 2 * k));
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("fpp_drained", 32'(spike_valid), 32'd0);

    // Asynchronous reset between edges with two events queued
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    spikes(2, 1'b0);
    chk("arst_pre_valid", 32'(spike_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(spike_valid), 32'd0);
    chk("arst_count", 32'(spike_count), 32'd0);
    cyc(1'b0, 32'h0, 1'b0);
    rst = 1'b1;

    // Synchronous clear with a spike-shaped sample in the clear cycle
    spikes(5, 1'b0);
    chk("clr_pre_ovf", 32'(overflow), 32'd1);
    cyc(1'b1, 32'h8000, 1'b0);
    cyc(1'b1, 32'h0000, 1'b0, 1'b1);
    chk("clr_valid", 32'(spike_valid), 32'd0);
    chk("clr_count", 32'(spike_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 32'h0000, 1'b0);
    chk("clr_prev_zero", 32'(spike_count), 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    rv = 32'h0;
        2:       rv = 32'(Q_ONE) + 32'($urandom_range(0, 255));
        3:       rv = -32'(Q_ONE);
        default: rv = $urandom;
      endcase
      cyc(1'($urandom_range(0, 9) < 7), rv, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 99) == 0));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
